// File: rtl/gmem_port_arbiter.sv
// gmem_port_arbiter
//   Round-robin arbiter sharing one graph_memory read port among NUM_REQ
//   requesters. One request is accepted per cycle and issued through a
//   register. Each issued request's requester index is pushed into an
//   in-order ID FIFO, and returning words are routed back by popping it.
//
// Ports
//   clk_in           clock
//   rst_n_in         asynchronous active-low reset
//   req_valid_in     per-requester request valid
//   req_addr_in      per-requester request address (unpacked array)
//   req_ready_out    combinational one-hot grant (0 when FIFO full/in reset)
//   mem_req_out      registered address to the memory port
//   mem_valid_out    one-cycle read strobe to the memory port
//   mem_data_in      read data from memory
//   mem_valid_in     read data valid (responses return in issue order)
//   resp_data_out    registered response data, shared by all requesters
//   resp_valid_out   registered one-hot response strobe
//   outstanding_out  issued requests not yet returned
//   err_out          sticky: response arrived with nothing outstanding
module gmem_port_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  input  logic [ADDR_WIDTH-1:0]              req_addr_in [NUM_REQ],
  output logic [NUM_REQ-1:0]                 req_ready_out,
  output logic [ADDR_WIDTH-1:0]              mem_req_out,
  output logic                               mem_valid_out,
  input  logic [DATA_WIDTH-1:0]              mem_data_in,
  input  logic                               mem_valid_in,
  output logic [DATA_WIDTH-1:0]              resp_data_out,
  output logic [NUM_REQ-1:0]                 resp_valid_out,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_out,
  output logic                               err_out
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] FULL  = CW'(MAX_OUTSTANDING);
  localparam logic [IW-1:0] LAST  = IW'(NUM_REQ - 1);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  logic          grant_vld;
  logic [IW-1:0] rd_id;
  logic          pop;
  logic          spurious;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] id_fifo [MAX_OUTSTANDING];
  int unsigned   cand;

  // Round-robin search starting at rr_ptr. Uses the count before any pop
  // this cycle, so a returning response never frees a slot the same cycle.
  always_comb begin
    grant_vld     = 1'b0;
    grant_idx     = '0;
    cand          = 0;
    req_ready_out = '0;
    if (rst_n_in && (count != FULL)) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = (32'(rr_ptr) + k) % NUM_REQ;
        if (!grant_vld && req_valid_in[IW'(cand)]) begin
          grant_vld = 1'b1;
          grant_idx = IW'(cand);
        end
      end
    end
    if (grant_vld) req_ready_out[grant_idx] = 1'b1;
  end

  assign pop             = mem_valid_in && (count != '0);
  assign spurious        = mem_valid_in && (count == '0);
  assign rd_id           = id_fifo[rd_ptr];
  assign outstanding_out = count;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_req_out    <= '0;
      mem_valid_out  <= 1'b0;
      resp_data_out  <= '0;
      resp_valid_out <= '0;
      err_out        <= 1'b0;
      rr_ptr         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      mem_valid_out  <= grant_vld;
      resp_valid_out <= '0;
      if (grant_vld) begin
        mem_req_out <= req_addr_in[grant_idx];
        wr_ptr      <= wr_ptr + PW'(1);
        rr_ptr      <= (grant_idx == LAST) ? '0 : grant_idx + IW'(1);
      end
      if (pop) begin
        resp_valid_out <= NUM_REQ'(1) << rd_id;
        resp_data_out  <= mem_data_in;
        rd_ptr         <= rd_ptr + PW'(1);
      end
      if (spurious) err_out <= 1'b1;
      if (grant_vld && !pop)      count <= count + CW'(1);
      else if (!grant_vld && pop) count <= count - CW'(1);
    end
  end

  // ID storage needs no reset: entries are only read behind a valid push.
  always_ff @(posedge clk_in) begin
    if (grant_vld) id_fifo[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_gmem_port_arbiter.sv
module tb_gmem_port_arbiter;
  localparam int N = 2, AW = 32, DW = 32, MAXO = 4, CW = $clog2(MAXO) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  valid = '0;
  logic [AW-1:0] addr [N];
  logic [N-1:0]  ready;
  logic [AW-1:0] mem_req;
  logic          mem_vo;
  logic          mv = 1'b0;
  logic [DW-1:0] md = '0;
  logic [DW-1:0] resp_data;
  logic [N-1:0]  resp_valid;
  logic [CW-1:0] outstanding;
  logic          err;

  always #5 clk = ~clk;

  gmem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(valid), .req_addr_in(addr),
    .req_ready_out(ready), .mem_req_out(mem_req), .mem_valid_out(mem_vo),
    .mem_data_in(md), .mem_valid_in(mv), .resp_data_out(resp_data),
    .resp_valid_out(resp_valid), .outstanding_out(outstanding), .err_out(err));

  // memory model state
  typedef struct { logic [DW-1:0] data; int due; } mem_t;
  mem_t mq[$];
  int   lat = 2;
  bit   hold = 0;
  int   release_n = 0;
  bit   spur_req = 0;
  bit   single_mode = 0;
  int   cyc = 0;

  // reference model state
  int            m_rr = 0;
  int            m_ids[$];
  logic [AW-1:0] m_addrs[$];
  bit            m_err = 0;
  logic          exp_mem_v = 0;
  logic [AW-1:0] exp_mem_addr = '0;
  logic [N-1:0]  exp_resp_v = '0;
  logic [DW-1:0] exp_resp_d = '0;
  logic [N-1:0]  last_grant = '0;

  int n_checks = 0, n_pass = 0;

  function automatic logic [DW-1:0] data_of(logic [AW-1:0] a);
    return single_mode ? DW'(32'hAB) : DW'(a + 32'h100);
  endfunction

  function automatic logic [N-1:0] model_grant();
    if (!rst_n || m_ids.size() >= MAXO) return '0;
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (valid[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_ids.delete(); m_addrs.delete(); m_err = 0;
    exp_mem_v = 0; exp_mem_addr = '0; exp_resp_v = '0; exp_resp_d = '0;
    mq.delete(); mv = 0; md = '0; release_n = 0; spur_req = 0;
  endtask

  // One clock: model update at the edge, memory model at the falling edge.
  task automatic step();
    logic [N-1:0] g;
    g = model_grant();
    last_grant = g;
    @(posedge clk);
    if (rst_n) begin
      exp_resp_v = '0;
      if (mv) begin
        if (m_ids.size() > 0) begin
          int h = m_ids.pop_front();
          logic [AW-1:0] a = m_addrs.pop_front();
          exp_resp_v = N'(1) << h;
          exp_resp_d = data_of(a);
        end else m_err = 1;
      end
      exp_mem_v = (g != 0);
      for (int i = 0; i < N; i++) if (g[i]) begin
        m_ids.push_back(i); m_addrs.push_back(addr[i]);
        exp_mem_addr = addr[i]; m_rr = (i + 1) % N;
      end
    end
    @(negedge clk);
    cyc++;
    if (mem_vo) mq.push_back('{data: data_of(mem_req), due: cyc + 1 + lat});
    mv = 0;
    if (spur_req) begin
      mv = 1; md = $urandom; spur_req = 0;
    end else if (mq.size() > 0 && mq[0].due <= cyc && (!hold || release_n > 0)) begin
      mem_t e = mq.pop_front();
      mv = 1; md = e.data;
      if (hold) release_n--;
    end
  endtask

  task automatic test_reset();
    valid = '1; addr[0] = 32'h1234; addr[1] = 32'h5678;
    #23;
    n_checks++; if (ready !== '0) $display("FAIL reset_ready: got %b want 0", ready); else n_pass++;
    n_checks++; if (mem_vo !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_vo); else n_pass++;
    n_checks++; if (mem_req !== '0) $display("FAIL reset_mem_req: got %h want 0", mem_req); else n_pass++;
    n_checks++; if (resp_valid !== '0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== '0) $display("FAIL reset_resp_data: got %h want 0", resp_data); else n_pass++;
    n_checks++; if (outstanding !== '0) $display("FAIL reset_outstanding: got %0d want 0", outstanding); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    @(negedge clk);
    rst_n = 1; valid = '0; model_reset();
  endtask

  task automatic test_single();
    int t; bit seen;
    single_mode = 1; lat = 2; hold = 0;
    valid = 2'b10; addr[1] = 32'h10;
    #1;
    n_checks++; if (ready !== 2'b10) $display("FAIL single_ready: got %b want 10", ready); else n_pass++;
    step(); t = cyc; valid = '0;
    n_checks++; if (mem_vo !== 1'b1 || mem_req !== 32'h10)
      $display("FAIL single_issue: got v=%b a=%h want v=1 a=10", mem_vo, mem_req); else n_pass++;
    n_checks++; if (outstanding !== 1) $display("FAIL single_outstanding1: got %0d want 1", outstanding); else n_pass++;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (resp_valid !== '0) seen = 1;
    end
    n_checks++; if (!seen || cyc - t != 4)
      $display("FAIL single_latency: got seen=%0d cycles=%0d want 4", seen, cyc - t); else n_pass++;
    n_checks++; if (resp_valid !== 2'b10 || resp_data !== 32'hAB)
      $display("FAIL single_resp: got v=%b d=%h want v=10 d=ab", resp_valid, resp_data); else n_pass++;
    n_checks++; if (outstanding !== 0) $display("FAIL single_outstanding0: got %0d want 0", outstanding); else n_pass++;
    step();
    single_mode = 0;
  endtask

  task automatic test_contention();
    int rc [N]; int gi; logic [AW-1:0] sent;
    lat = 1; hold = 0;
    foreach (rc[i]) rc[i] = 0;
    for (int i = 0; i < N; i++) addr[i] = $urandom & 32'h00FF_FFF0;
    valid = '1;
    for (int k = 0; k < 6; k++) begin
      #1;
      gi = k % 2; sent = addr[gi];
      n_checks++; if (ready !== (N'(1) << gi))
        $display("FAIL contention_grant%0d: got %b want %b", k, ready, N'(1) << gi); else n_pass++;
      step();
      n_checks++; if (mem_vo !== 1'b1 || mem_req !== sent)
        $display("FAIL contention_issue%0d: got v=%b a=%h want v=1 a=%h", k, mem_vo, mem_req, sent); else n_pass++;
      addr[gi] = $urandom & 32'h00FF_FFF0;
      n_checks++; if (resp_valid !== exp_resp_v || (exp_resp_v != 0 && resp_data !== exp_resp_d))
        $display("FAIL contention_resp: got v=%b d=%h want v=%b d=%h", resp_valid, resp_data, exp_resp_v, exp_resp_d); else n_pass++;
      for (int i = 0; i < N; i++) if (resp_valid[i]) rc[i]++;
    end
    valid = '0;
    for (int k = 0; k < 20 && m_ids.size() > 0; k++) begin
      step();
      n_checks++; if (resp_valid !== exp_resp_v || (exp_resp_v != 0 && resp_data !== exp_resp_d))
        $display("FAIL contention_resp: got v=%b d=%h want v=%b d=%h", resp_valid, resp_data, exp_resp_v, exp_resp_d); else n_pass++;
      for (int i = 0; i < N; i++) if (resp_valid[i]) rc[i]++;
    end
    n_checks++; if (outstanding !== 0) $display("FAIL contention_drain: got %0d want 0", outstanding); else n_pass++;
    n_checks++; if (rc[0] != 3 || rc[1] != 3)
      $display("FAIL contention_routing: got %0d/%0d want 3/3", rc[0], rc[1]); else n_pass++;
  endtask

  task automatic test_backpressure();
    lat = 2; hold = 1;
    for (int i = 0; i < N; i++) addr[i] = $urandom;
    valid = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (ready !== model_grant() || ready === '0)
        $display("FAIL bp_fill_ready%0d: got %b want %b", k, ready, model_grant()); else n_pass++;
      step();
      for (int i = 0; i < N; i++) if (last_grant[i]) addr[i] = $urandom;
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (ready !== '0 || outstanding !== 4)
        $display("FAIL bp_full: got r=%b n=%0d want r=0 n=4", ready, outstanding); else n_pass++;
      step();
    end
    release_n = 1;
    step();
    #1;
    n_checks++; if (mv !== 1'b1 || ready !== '0)
      $display("FAIL bp_no_same_cycle_credit: got mv=%b r=%b want mv=1 r=0", mv, ready); else n_pass++;
    step();
    #1;
    n_checks++; if (resp_valid !== exp_resp_v || exp_resp_v === '0 || resp_data !== exp_resp_d)
      $display("FAIL bp_resp: got v=%b d=%h want v=%b d=%h", resp_valid, resp_data, exp_resp_v, exp_resp_d); else n_pass++;
    n_checks++; if (outstanding !== 3 || ready === '0 || ready !== model_grant())
      $display("FAIL bp_reenable: got r=%b n=%0d want r=%b n=3", ready, outstanding, model_grant()); else n_pass++;
    step();
    #1;
    n_checks++; if (ready !== '0 || outstanding !== 4)
      $display("FAIL bp_refull: got r=%b n=%0d want r=0 n=4", ready, outstanding); else n_pass++;
    valid = '0; hold = 0;
    for (int k = 0; k < 30 && m_ids.size() > 0; k++) begin
      step();
      n_checks++; if (resp_valid !== exp_resp_v || (exp_resp_v != 0 && resp_data !== exp_resp_d))
        $display("FAIL bp_drain_resp: got v=%b d=%h want v=%b d=%h", resp_valid, resp_data, exp_resp_v, exp_resp_d); else n_pass++;
    end
    n_checks++; if (outstanding !== 0) $display("FAIL bp_drain: got %0d want 0", outstanding); else n_pass++;
  endtask

  task automatic test_push_pop();
    int both = 0;
    lat = 2; hold = 0;
    for (int k = 0; k < 12; k++) begin
      valid = '0;
      if (k % 2 == 0) begin
        int r = $urandom_range(0, N - 1);
        valid[r] = 1'b1; addr[r] = $urandom;
      end
      #1;
      n_checks++; if (ready !== model_grant())
        $display("FAIL pp_ready: got %b want %b", ready, model_grant()); else n_pass++;
      step();
      n_checks++; if (resp_valid !== exp_resp_v || (exp_resp_v != 0 && resp_data !== exp_resp_d))
        $display("FAIL pp_resp: got v=%b d=%h want v=%b d=%h", resp_valid, resp_data, exp_resp_v, exp_resp_d); else n_pass++;
      if (last_grant != 0 && exp_resp_v != 0) begin
        both++;
        n_checks++; if (outstanding !== 2) $display("FAIL pp_count: got %0d want 2", outstanding); else n_pass++;
      end
    end
    n_checks++; if (both < 3) $display("FAIL pp_overlap: got %0d want >=3", both); else n_pass++;
    valid = '0;
    for (int k = 0; k < 20 && m_ids.size() > 0; k++) begin
      step();
      n_checks++; if (resp_valid !== exp_resp_v || (exp_resp_v != 0 && resp_data !== exp_resp_d))
        $display("FAIL pp_drain_resp: got v=%b d=%h want v=%b d=%h", resp_valid, resp_data, exp_resp_v, exp_resp_d); else n_pass++;
    end
  endtask

  task automatic test_spurious();
    bit seen;
    spur_req = 1;
    step();
    step();
    n_checks++; if (err !== 1'b1 || resp_valid !== '0 || outstanding !== 0)
      $display("FAIL spur_set: got e=%b v=%b n=%0d want e=1 v=0 n=0", err, resp_valid, outstanding); else n_pass++;
    step();
    n_checks++; if (err !== 1'b1) $display("FAIL spur_sticky: got %b want 1", err); else n_pass++;
    valid = 2'b01; addr[0] = $urandom;
    #1;
    n_checks++; if (ready !== model_grant()) $display("FAIL spur_ready: got %b want %b", ready, model_grant()); else n_pass++;
    step(); valid = '0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (resp_valid !== '0) seen = 1;
    end
    n_checks++; if (!seen || resp_valid !== 2'b01 || resp_data !== exp_resp_d)
      $display("FAIL spur_followup: got v=%b d=%h want v=01 d=%h", resp_valid, resp_data, exp_resp_d); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL spur_sticky2: got %b want 1", err); else n_pass++;
  endtask

  task automatic test_random();
    lat = $urandom_range(0, 3);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        if (last_grant[i]) begin
          valid[i] = $urandom_range(0, 1); addr[i] = $urandom;
        end else if (!valid[i] && $urandom_range(0, 2) == 0) begin
          valid[i] = 1'b1; addr[i] = $urandom;
        end
      end
      last_grant = '0;
      hold = ($urandom_range(0, 3) == 0);
      #1;
      n_checks++; if (ready !== model_grant())
        $display("FAIL rnd_ready: got %b want %b", ready, model_grant()); else n_pass++;
      step();
      n_checks++; if (mem_vo !== exp_mem_v || (exp_mem_v && mem_req !== exp_mem_addr))
        $display("FAIL rnd_issue: got v=%b a=%h want v=%b a=%h", mem_vo, mem_req, exp_mem_v, exp_mem_addr); else n_pass++;
      n_checks++; if (resp_valid !== exp_resp_v || (exp_resp_v != 0 && resp_data !== exp_resp_d))
        $display("FAIL rnd_resp: got v=%b d=%h want v=%b d=%h", resp_valid, resp_data, exp_resp_v, exp_resp_d); else n_pass++;
      n_checks++; if (outstanding !== CW'(m_ids.size()) || err !== m_err)
        $display("FAIL rnd_state: got n=%0d e=%b want n=%0d e=%b", outstanding, err, m_ids.size(), m_err); else n_pass++;
    end
    valid = '0; hold = 0;
    for (int k = 0; k < 40 && m_ids.size() > 0; k++) begin
      step();
      n_checks++; if (resp_valid !== exp_resp_v || (exp_resp_v != 0 && resp_data !== exp_resp_d))
        $display("FAIL rnd_drain_resp: got v=%b d=%h want v=%b d=%h", resp_valid, resp_data, exp_resp_v, exp_resp_d); else n_pass++;
    end
    n_checks++; if (outstanding !== 0) $display("FAIL rnd_drain: got %0d want 0", outstanding); else n_pass++;
  endtask

  task automatic test_reset_mid();
    lat = 2; hold = 1;
    valid = 2'b01; addr[0] = $urandom; step();
    valid = 2'b10; addr[1] = $urandom; step();
    valid = 2'b01; addr[0] = $urandom; step();
    valid = '1;
    #1;
    n_checks++; if (outstanding !== 3) $display("FAIL mid_pre: got %0d want 3", outstanding); else n_pass++;
    #1;
    rst_n = 0; model_reset();
    #1;
    n_checks++; if (ready !== '0 || mem_vo !== 1'b0 || mem_req !== '0)
      $display("FAIL mid_req_side: got r=%b v=%b a=%h want 0", ready, mem_vo, mem_req); else n_pass++;
    n_checks++; if (resp_valid !== '0 || resp_data !== '0 || outstanding !== 0 || err !== 1'b0)
      $display("FAIL mid_resp_side: got v=%b d=%h n=%0d e=%b want 0", resp_valid, resp_data, outstanding, err); else n_pass++;
    @(negedge clk);
    rst_n = 1; hold = 0;
    #1;
    n_checks++; if (outstanding !== 0 || ready !== 2'b01)
      $display("FAIL mid_release: got n=%0d r=%b want n=0 r=01", outstanding, ready); else n_pass++;
    step();
    n_checks++; if (mem_vo !== 1'b1 || mem_req !== addr[0])
      $display("FAIL mid_issue: got v=%b a=%h want v=1 a=%h", mem_vo, mem_req, addr[0]); else n_pass++;
    valid = '0;
    for (int k = 0; k < 10; k++) step();
    n_checks++; if (outstanding !== 0 || err !== 1'b0)
      $display("FAIL mid_final: got n=%0d e=%b want n=0 e=0", outstanding, err); else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addr[0] = '0; addr[1] = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_push_pop();
    test_spurious();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gmem_port_arbiter.md
# gmem_port_arbiter

Round-robin arbiter that shares one read port of `graph_memory` among `NUM_REQ` requesters, for example the search controller's position lookups and `graph_fetch`'s second request stream. It accepts one request per cycle and issues it to the memory port through a register. It tags each issued request with the requester index in an in-order ID FIFO, then routes each returned word to the requester that asked for it. This replaces state-based muxing of the port with a handshake any number of clients can use concurrently.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `ADDR_WIDTH`, default 32: memory address width.
- `DATA_WIDTH`, default 32: memory data width.
- `MAX_OUTSTANDING`, default 4: ID FIFO depth; must be a power of 2 and at least the memory read latency.

Ports:
- `clk_in`  in  1: clock.
- `rst_n_in`  in  1: reset, asynchronous, active-low.
- `req_valid_in`  in  [NUM_REQ-1:0]: request valid, one bit per requester.
- `req_addr_in`  in  [ADDR_WIDTH-1:0] [NUM_REQ-1:0]: request address per requester (unpacked array).
- `req_ready_out`  out  [NUM_REQ-1:0]: combinational grant; the request is accepted when valid and ready are both high.
- `mem_req_out`  out  ADDR_WIDTH: address to the memory port.
- `mem_valid_out`  out  1: one-cycle read strobe to the memory port.
- `mem_data_in`  in  DATA_WIDTH: read data from memory.
- `mem_valid_in`  in  1: read data valid; responses return in issue order.
- `resp_data_out`  out  DATA_WIDTH: routed read data, shared by all requesters.
- `resp_valid_out`  out  [NUM_REQ-1:0]: one-hot response strobe.
- `outstanding_out`  out  $clog2(MAX_OUTSTANDING)+1: count of issued requests not yet returned.
- `err_out`  out  1: sticky; set when `mem_valid_in` arrives while no request is outstanding.

## Operation
- Reset (asynchronous assert, synchronous release) clears all outputs, `outstanding_out`, the FIFO pointers, `err_out` and the round-robin pointer (`rr_ptr` = 0). The reset values of all outputs are 0, and `req_ready_out` = 0 while reset is held.
- **Arbitration.** When `outstanding_out < MAX_OUTSTANDING`, grant the first `i` with `req_valid_in[i]` = 1, searching `rr_ptr`, `rr_ptr`+1, … with wrap mod `NUM_REQ`.
  - At most one bit of `req_ready_out` is high per cycle.
  - When the FIFO is full, all ready bits are 0.
- **Accept.** On an accepted request from requester `g`:
  - `mem_req_out` ← `req_addr_in[g]` and `mem_valid_out` ← 1, registered.
  - Push `g` into the ID FIFO.
  - `rr_ptr` ← (`g`+1) mod `NUM_REQ`.
  - In any cycle without an accept, `mem_valid_out` ← 0 and `mem_req_out` holds its last value.
- **Response.** On `mem_valid_in`, pop ID `h`, then register `resp_data_out` ← `mem_data_in` and `resp_valid_out` ← (1 << `h`). In any cycle without a response, `resp_valid_out` ← 0 and `resp_data_out` holds.
- **Simultaneous accept and response.** Push and pop happen in the same cycle and the count is unchanged. Readiness is computed from the count before the pop; there is no same-cycle credit.
- **Spurious response.** `mem_valid_in` with the count at 0 sets `err_out`, drops the data, does not pop, and leaves the FIFO pointers unchanged. `err_out` clears only on reset.
- **Requester holds.** A requester keeps `req_valid_in` and `req_addr_in` stable until accepted. The arbiter does not check this; a dropped or changed request is simply re-arbitrated next cycle.
- **Pointer wrap.** FIFO pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally. The count is one bit wider, so full and empty are unambiguous.
- **Reset mid-operation.** In-flight IDs are discarded. Memory responses that arrive after reset releases count as spurious and set `err_out`; the system resets the memory together with the arbiter.

## Timing
- Request to memory: accept at edge `t` produces `mem_valid_out` = 1 in cycle `t`+1, so the arbiter adds 1 cycle.
- Memory to response: `mem_valid_in` at edge `r` produces `resp_valid_out` in cycle `r`+1, so the arbiter adds 1 cycle.
- End-to-end latency is memory latency + 2 cycles.
- Throughput is 1 request per cycle per arbiter as long as outstanding requests stay below `MAX_OUTSTANDING`.
- With `MAX_OUTSTANDING` greater than or equal to round-trip latency + 1, the arbiter never stalls.
- `req_ready_out` depends combinationally on `req_valid_in`, `rr_ptr` and the count. No output depends combinationally on `mem_valid_in`.

## Test plan
- **Single request.** Reset, then requester 1 sends addr 0x10 with memory model latency 2 returning 0xAB. Required: `req_ready_out` = 2'b10 in the same cycle, `mem_valid_out` with addr 0x10 one cycle later, `resp_valid_out` = 2'b10 with data 0xAB 4 cycles after accept, `outstanding_out` back to 0.
- **Contention fairness.** Both requesters hold valid for 6 cycles. Required: grants alternate 0,1,0,1,0,1 and each response is routed to the requester that issued it (data = addr + 0x100).
- **Backpressure.** `MAX_OUTSTANDING` = 4 and the memory model withholds responses. Required: four accepts, then ready = 0 and `outstanding_out` = 4. Releasing one response re-enables ready on the following cycle only.
- **Simultaneous push and pop.** Keep the count at 2 with a response and an accept in the same cycle. Required: count stays 2 and the IDs remain in order.
- **Spurious response.** Pulse `mem_valid_in` with the count at 0. Required: `err_out` = 1 and held, no `resp_valid_out`, and a later normal transaction still completes correctly.
- **Reset mid-operation.** Assert `rst_n_in` low asynchronously (between edges) with 3 requests outstanding. Required: all outputs are 0 immediately, and after release `outstanding_out` = 0 and `rr_ptr` = 0.
